// File: rtl/seq_detect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_ctrl_pkg
//  Brief    : Shared state encoding, defaults and helpers for seq_detect_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
package seq_ctrl_pkg;

    localparam int PAT_W_DEF = 16;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_SETUP = 2'd1;
    localparam state_t c_ST_RUN   = 2'd2;
    localparam state_t c_ST_DONE  = 2'd3;

    // Requested bit count limited to the width of the test word.
    function automatic logic [4:0] clamp_nbits(input logic [4:0] nb, input logic [4:0] lim);
        return (nb > lim) ? lim : nb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detect_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_ctrl_if
//  Brief    : Control/stimulus bundle between board inputs, sequencer and detector.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_detect_ctrl_if
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = 5
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [4:0]       nbits;
    logic             det_z;
    logic             w_out;
    logic             step;
    logic             det_rst;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_count;

    modport master (
        input  start, pattern, nbits, det_z,
        output w_out, step, det_rst, busy, done, match_count
    );

    modport slave (
        output start, pattern, nbits, det_z,
        input  w_out, step, det_rst, busy, done, match_count
    );
endinterface
`default_nettype wire

// File: rtl/seq_detect_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tick_gen
//  Brief    : Prescaler; tick asserts on the last cycle of each TICK_DIV window.
//  Revision : 1.0  initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clr,
    input  wire logic en,
    output logic      tick
);
    localparam int c_CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    generate
        if (TICK_DIV == 1) begin : g_passthru
            assign tick = en;
        end else begin : g_count
            logic [c_CW-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (reset || clr) begin
                    cnt_q <= '0;
                end else if (en) begin
                    cnt_q <= (cnt_q == c_CW'(TICK_DIV - 1)) ? '0 : cnt_q + 1'b1;
                end
            end

            assign tick = en && (cnt_q == c_CW'(TICK_DIV - 1));
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_ctrl
//  Brief    : Feeds a latched test word MSB-first into the 10010 detector and
//             counts its detections.
//  Revision : 1.0  initial release
// ============================================================================
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int PAT_W    = PAT_W_DEF,
    parameter int CNT_W    = 5
) (
    input  wire logic         clk,
    input  wire logic         reset,
    seq_detect_ctrl_if.master bus
);
    localparam int c_REM_W = $clog2(PAT_W + 1);

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   shreg_q, shreg_d;
    logic [c_REM_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;
    logic               w_tick;
    logic               w_in_run;

    assign w_in_run = (state_q == c_ST_RUN);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (!w_in_run),
        .en    (w_in_run),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.nbits != 5'd0) ? c_ST_SETUP : c_ST_DONE;
                end
            end
            c_ST_SETUP: state_d = c_ST_RUN;
            c_ST_RUN: begin
                if (w_tick && (remaining_q == c_REM_W'(1))) begin
                    state_d = c_ST_DONE;
                end
            end
            c_ST_DONE: state_d = c_ST_IDLE;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output.
    always_comb begin
        bus.w_out       = 1'b0;
        bus.step        = 1'b0;
        bus.det_rst     = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.match_count = match_count_q;
        case (state_q)
            c_ST_SETUP: begin
                bus.w_out   = shreg_q[PAT_W-1];
                bus.det_rst = 1'b1;
                bus.busy    = 1'b1;
            end
            c_ST_RUN: begin
                bus.w_out = shreg_q[PAT_W-1];
                bus.step  = w_tick;
                bus.busy  = 1'b1;
            end
            c_ST_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        shreg_d       = shreg_q;
        remaining_d   = remaining_q;
        match_count_d = match_count_q;
        if ((state_q == c_ST_IDLE) && bus.start) begin
            match_count_d = '0;
            if (bus.nbits != 5'd0) begin
                shreg_d     = bus.pattern;
                remaining_d = c_REM_W'(clamp_nbits(bus.nbits, 5'(PAT_W)));
            end
        end else if (w_in_run && w_tick) begin
            if (bus.det_z && (match_count_q != {CNT_W{1'b1}})) begin
                match_count_d = match_count_q + 1'b1;
            end
            shreg_d     = shreg_q << 1;
            remaining_d = remaining_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q       <= '0;
            remaining_q   <= '0;
            match_count_q <= '0;
        end else begin
            shreg_q       <= shreg_d;
            remaining_q   <= remaining_d;
            match_count_q <= match_count_d;
        end
    end
endmodule
`default_nettype wire
